// File: rtl/load_store_unit.sv
// RV32 load/store stage: one request at a time, sub-word stores via read-modify-write.
// Latency load 2, word store 2, sub-word store 3, fault 1; req_ready only in IDLE, requests are never queued.
module load_store_unit #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  resp_access_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(DEPTH - 4);

  state_t      state;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic [ADDR_WIDTH-1:0] acc_aligned;
  logic                  misaligned;
  logic                  out_of_range;
  logic [31:0]           lw;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  assign req_ready    = (state == IDLE);
  assign acc_aligned  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign misaligned   = (req_size == 2'd3) ||
                        (req_size == 2'd1 && req_addr[0]) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign out_of_range = acc_aligned > MAX_ADDR;

  // Memory port returns the lowest address in the top byte; lw puts byte k at lw[8k+:8].
  assign lw = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]};

  always_comb begin
    load_data = lw;
    case (lat_size)
      2'd0: begin
        load_data[7:0]  = lw[{lat_off, 3'b000} +: 8];
        load_data[31:8] = lat_unsigned ? 24'h0 : {24{load_data[7]}};
      end
      2'd1: begin
        load_data[15:0]  = lw[{lat_off[1], 4'b0000} +: 16];
        load_data[31:16] = lat_unsigned ? 16'h0 : {16{load_data[15]}};
      end
      default: load_data = lw;
    endcase
  end

  always_comb begin
    merged = lw;
    if (lat_size == 2'd0)
      merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
    else
      merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      lat_size          <= 2'd0;
      lat_unsigned      <= 1'b0;
      lat_off           <= 2'd0;
      lat_wdata         <= 16'h0;
      resp_valid        <= 1'b0;
      resp_rdata        <= 32'h0;
      resp_misaligned   <= 1'b0;
      resp_access_fault <= 1'b0;
      mem_addr          <= '0;
      mem_we            <= 1'b0;
      mem_wdata         <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size          <= req_size;
            lat_unsigned      <= req_unsigned;
            lat_off           <= req_addr[1:0];
            lat_wdata         <= req_wdata[15:0];
            mem_addr          <= acc_aligned;
            resp_rdata        <= 32'h0;
            resp_misaligned   <= 1'b0;
            resp_access_fault <= 1'b0;
            if (misaligned) begin
              resp_misaligned <= 1'b1;
              resp_valid      <= 1'b1;
              state           <= RESP;
            end else if (out_of_range) begin
              resp_access_fault <= 1'b1;
              resp_valid        <= 1'b1;
              state             <= RESP;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_size == 2'd2) begin
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
              state     <= WRITE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW_READ: begin
          mem_wdata <= merged;
          mem_we    <= 1'b1;
          state     <= WRITE;
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid        <= 1'b0;
          resp_rdata        <= 32'h0;
          resp_misaligned   <= 1'b0;
          resp_access_fault <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory behind the port, byte-level reference model.
module tb_load_store_unit;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_access_fault;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.DEPTH(DEPTH), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_access_fault(resp_access_fault),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device seen by the DUT, and the independent expected contents.
  logic [7:0] tb_mem  [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  logic [9:0] ia;
  assign ia = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {tb_mem[ia], tb_mem[ia + 10'd1], tb_mem[ia + 10'd2], tb_mem[ia + 10'd3]};

  always @(posedge clk) begin
    if (mem_we)
      for (int k = 0; k < 4; k++) tb_mem[int'(ia) + k] <= mem_wdata[8*k +: 8];
  end

  // Observations of the last transaction.
  int          o_lat, o_we_cyc, o_we_cnt;
  logic [31:0] o_rdata, o_waddr, o_wdata;
  logic        o_mis, o_af, o_rdy_bad;

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    o_lat = -1; o_we_cyc = -1; o_we_cnt = 0; o_rdata = 32'hx;
    o_waddr = 32'h0; o_wdata = 32'h0; o_mis = 1'b0; o_af = 1'b0; o_rdy_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we) begin
        o_we_cnt++;
        if (o_we_cyc < 0) o_we_cyc = c;
        o_waddr = mem_addr; o_wdata = mem_wdata;
      end
      if (req_ready) o_rdy_bad = 1'b1;
      if (resp_valid) begin
        o_lat = c; o_rdata = resp_rdata; o_mis = resp_misaligned; o_af = resp_access_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(size); i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
    if (!uns && size == 2'd0) v = {{24{v[7]}}, v[7:0]};
    if (!uns && size == 2'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic test_reset;
    #3;
    tests++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_misaligned !== 1'b0 ||
        resp_access_fault !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: rv=%b rd=%h mis=%b af=%b ma=%h we=%b wd=%h, required all zero",
               resp_valid, resp_rdata, resp_misaligned, resp_access_fault, mem_addr, mem_we, mem_wdata);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b required 1", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loads;
    logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        uns [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] ex  [5] = '{32'hFFFFFF84, 32'h00000084, 32'hFFFF8433, 32'h00008433, 32'h84332211};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sz[i], uns[i], ad[i], 32'h0);
      tests++;
      if (o_lat !== 2 || o_rdata !== ex[i] || o_we_cnt !== 0 || o_mis || o_af) begin
        fails++;
        $display("FAIL load_%0d: lat=%0d rdata=%h we_cnt=%0d mis=%b af=%b, required lat=2 rdata=%h no write/fault",
                 i, o_lat, o_rdata, o_we_cnt, o_mis, o_af, ex[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB);
    ref_mem[32'h11] = 8'hAB;
    tests++;
    if (o_we_cyc !== 2 || o_we_cnt !== 1 || o_waddr !== 32'h10 || o_wdata !== 32'h8433AB11) begin
      fails++;
      $display("FAIL sb_write: we_cyc=%0d cnt=%0d addr=%h wdata=%h, required 2 1 00000010 8433ab11",
               o_we_cyc, o_we_cnt, o_waddr, o_wdata);
    end
    tests++;
    if (o_lat !== 3 || o_rdata !== 32'h0 || o_rdy_bad) begin
      fails++;
      $display("FAIL sb_resp: lat=%0d rdata=%h rdy_bad=%b, required lat=3 rdata=0 rdy_bad=0",
               o_lat, o_rdata, o_rdy_bad);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    tests++;
    if (o_rdata !== 32'h8433AB11) begin
      fails++;
      $display("FAIL sb_readback: got %h required 8433ab11", o_rdata);
    end
  endtask

  task automatic test_word_store;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) ref_mem[32 + i] = 8'(32'hDEADBEEF >> (8 * i));
    tests++;
    if (o_we_cyc !== 1 || o_we_cnt !== 1 || o_waddr !== 32'h20 || o_wdata !== 32'hDEADBEEF || o_lat !== 2) begin
      fails++;
      $display("FAIL sw: we_cyc=%0d cnt=%0d addr=%h wdata=%h lat=%0d, required 1 1 00000020 deadbeef 2",
               o_we_cyc, o_we_cnt, o_waddr, o_wdata, o_lat);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
    tests++;
    if (o_rdata !== 32'h000000EF) begin
      fails++;
      $display("FAIL lbu_20: got %h required 000000ef", o_rdata);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
    tests++;
    if (o_rdata !== 32'h000000DE) begin
      fails++;
      $display("FAIL lbu_23: got %h required 000000de", o_rdata);
    end
  endtask

  task automatic test_faults;
    logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd2, 2'd3};
    logic [31:0] ad [4] = '{32'h11, 32'h3FE, 32'h400, 32'h40};
    logic        mi [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        af [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_req(we[i], sz[i], 1'b0, ad[i], 32'h12345678);
      tests++;
      if (o_lat !== 1 || o_mis !== mi[i] || o_af !== af[i] || o_we_cnt !== 0 || o_rdata !== 32'h0) begin
        fails++;
        $display("FAIL fault_%0d: lat=%0d mis=%b af=%b we_cnt=%0d rdata=%h, required lat=1 mis=%b af=%b no write rdata=0",
                 i, o_lat, o_mis, o_af, o_we_cnt, o_rdata, mi[i], af[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic bad_we = 1'b0, bad_rv = 1'b0, bad_rdy = 1'b0, bad_mem = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h0000005A;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    if (mem_we || resp_valid) bad_we = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_we !== 1'b0) bad_we = 1'b1;
      if (resp_valid !== 1'b0) bad_rv = 1'b1;
      if (req_ready !== 1'b1) bad_rdy = 1'b1;
    end
    for (int i = 16; i < 20; i++) if (tb_mem[i] !== ref_mem[i]) bad_mem = 1'b1;
    tests++;
    if (bad_we || bad_rv || bad_rdy || bad_mem) begin
      fails++;
      $display("FAIL reset_abort: stray_we=%b stray_resp=%b not_ready=%b mem_changed=%b, required all 0",
               bad_we, bad_rv, bad_rdy, bad_mem);
    end
  endtask

  task automatic test_back_to_back;
    int acc1 = -1, acc2 = -1, r1 = -1, r2 = -1, bad = 0;
    logic [31:0] rd1 = 32'h0, rd2 = 32'h0;
    logic exp_rdy;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    for (int c = 0; c < 10; c++) begin
      exp_rdy = (c == 0) || (c == 3) || (c >= 6);
      if (req_ready !== exp_rdy) bad++;
      if (req_valid && req_ready) begin
        if (acc1 < 0) acc1 = c;
        else if (acc2 < 0) acc2 = c;
      end
      if (resp_valid) begin
        if (r1 < 0) begin r1 = c; rd1 = resp_rdata; end
        else if (r2 < 0) begin r2 = c; rd2 = resp_rdata; end
      end
      @(negedge clk);
      if (c == 0) begin
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h13;
      end
      if (acc2 >= 0) req_valid = 1'b0;
    end
    tests++;
    if (acc1 !== 0 || acc2 !== 3 || bad !== 0) begin
      fails++;
      $display("FAIL b2b_accept: acc1=%0d acc2=%0d ready_errors=%0d, required 0 3 0", acc1, acc2, bad);
    end
    tests++;
    if (r1 !== 2 || rd1 !== 32'h8433AB11 || r2 !== 5 || rd2 !== 32'h00000084) begin
      fails++;
      $display("FAIL b2b_resp: r1=%0d rd1=%h r2=%0d rd2=%h, required 2 8433ab11 5 00000084", r1, rd1, r2, rd2);
    end
  endtask

  task automatic test_random;
    logic        we, uns, mis, af;
    logic [1:0]  size;
    logic [31:0] addr, wdata, exp_rd;
    int          r, exp_lat, exp_we_cyc, mem_diff;
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      if (r < 8) addr = $urandom_range(0, DEPTH - 1);
      else if (r == 8) addr = $urandom_range(DEPTH - 8, DEPTH + 8);
      else addr = $urandom;
      if ($urandom_range(0, 1) == 1 && size != 2'd3) addr = addr & ~(32'(nbytes(size)) - 1);
      wdata = $urandom;
      mis = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
      af = !mis && ((addr & ~32'd3) > 32'(DEPTH - 4));
      exp_lat = (mis || af) ? 1 : (!we || size == 2'd2) ? 2 : 3;
      exp_we_cyc = (mis || af || !we) ? -1 : (size == 2'd2) ? 1 : 2;
      exp_rd = (mis || af || we) ? 32'h0 : model_load(size, uns, addr);
      do_req(we, size, uns, addr, wdata);
      if (!mis && !af && we)
        for (int i = 0; i < nbytes(size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      tests++;
      if (o_lat !== exp_lat || o_mis !== mis || o_af !== af || o_rdata !== exp_rd) begin
        fails++;
        $display("FAIL rand_%0d resp: we=%b size=%0d addr=%h lat=%0d mis=%b af=%b rd=%h, required lat=%0d mis=%b af=%b rd=%h",
                 it, we, size, addr, o_lat, o_mis, o_af, o_rdata, exp_lat, mis, af, exp_rd);
      end
      tests++;
      if (o_we_cyc !== exp_we_cyc || o_we_cnt !== (exp_we_cyc < 0 ? 0 : 1) ||
          (exp_we_cyc >= 0 && o_waddr !== (addr & ~32'd3))) begin
        fails++;
        $display("FAIL rand_%0d write: we_cyc=%0d cnt=%0d waddr=%h, required we_cyc=%0d waddr=%h",
                 it, o_we_cyc, o_we_cnt, o_waddr, exp_we_cyc, addr & ~32'd3);
      end
    end
    @(negedge clk);
    mem_diff = 0;
    for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) mem_diff++;
    tests++;
    if (mem_diff !== 0) begin
      fails++;
      $display("FAIL rand_memory: %0d bytes differ, required 0", mem_diff);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i] = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 8'h11; tb_mem[17] = 8'h22; tb_mem[18] = 8'h33; tb_mem[19] = 8'h84;
    for (int i = 16; i < 20; i++) ref_mem[i] = tb_mem[i];
    test_reset;
    test_loads;
    test_subword_store;
    test_word_store;
    test_faults;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-side memory access stage for the RISC-V core, sitting between the execute stage and the byte-addressed data memory. It accepts one load or store request at a time and converts RV32 LB/LBU/LH/LHU/LW/SB/SH/SW into aligned 32-bit memory-port accesses. Sub-word stores become a read-modify-write sequence because the memory port always writes 4 bytes. It also sign- or zero-extends loads and flags misaligned and out-of-range accesses.

Parameters:
DEPTH, 1024, data memory size in bytes (multiple of 4); accesses must satisfy aligned address <= DEPTH-4.
ADDR_WIDTH, 32, width of request and memory address.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  input  1  zero-extend load result (LBU/LHU); ignored for stores and words
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data in low bits
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_misaligned  output  1  misaligned or illegal-size fault, valid with resp_valid
resp_access_fault  output  1  out-of-range fault, valid with resp_valid
mem_addr  output  ADDR_WIDTH  word-aligned address to memory ({addr[ADDR_WIDTH-1:2],2'b00})
mem_we  output  1  memory write enable; the write commits on the rising edge ending the cycle
mem_wdata  output  32  bits [7:0] go to byte mem_addr, ..., bits [31:24] go to mem_addr+3
mem_rdata  input  32  combinational read: [31:24]=byte at mem_addr, ..., [7:0]=byte at mem_addr+3

Behaviour:
- Reset is async: state=IDLE; all latched fields, resp_rdata, resp_valid, resp_misaligned, resp_access_fault, mem_addr, mem_we and mem_wdata are 0. A reset asserted in any state aborts the access. No mem_we is issued after reset assertion, and no resp_valid is produced for the aborted request.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: req_ready=1. When req_valid=1, the unit latches we, size, unsigned, addr and wdata, then checks faults in priority order:
  - Misaligned: size==3, half with addr[0]=1, or word with addr[1:0]!=0. Next state RESP with resp_misaligned=1.
  - Access fault: aligned addr > DEPTH-4. Next state RESP with resp_access_fault=1.
  - Otherwise: a load goes to LOAD, a word store to WRITE, a byte or half store to RMW_READ.
- Faulted requests never assert mem_we.
- Byte-order conversion: lw = {mem_rdata[7:0], mem_rdata[15:8], mem_rdata[23:16], mem_rdata[31:24]}. Byte at offset k is lw[8k+:8].
- LOAD: extract lw[8*off+:8] (byte) or lw[16*off[1]+:16] (half), sign- or zero-extend it, or take all of lw (word). Register the result into resp_rdata. Next state RESP.
- RMW_READ: register lw, replacing the addressed byte with wdata[7:0] or the addressed half with wdata[15:0]. Next state WRITE.
- WRITE: mem_we=1 for exactly one cycle. mem_wdata is the merged word (sub-word store) or req_wdata (word store). Next state RESP.
- RESP: resp_valid=1 for one cycle with the flags and data; req_ready=0. Next state IDLE.
- mem_addr holds the latched aligned address from the cycle after acceptance until the return to IDLE.
- Latency, with acceptance at cycle T:
  - load: resp_valid at T+2
  - word store: mem_we at T+1, resp_valid at T+2
  - sub-word store: mem_we at T+2, resp_valid at T+3
  - fault: resp_valid at T+1
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after RESP. A req_valid held high during busy states is ignored, not queued.

Test Plan:
- Preload bytes 0x10..0x13 = 0x11,0x22,0x33,0x84 (mem_rdata=0x11223384). LB 0x13 -> resp_rdata 0xFFFFFF84 at T+2; LBU 0x13 -> 0x00000084; LH 0x12 -> 0xFFFF8433; LHU 0x12 -> 0x00008433; LW 0x10 -> 0x84332211.
- SB 0x11, wdata 0x000000AB on the same data -> RMW_READ at T+1; mem_we=1 at T+2 with mem_addr=0x10, mem_wdata=0x8433AB11; resp_valid at T+3. A following LW 0x10 -> 0x8433AB11.
- SW 0x20 with 0xDEADBEEF -> mem_we at T+1 only, resp_valid at T+2. LBU 0x20 -> 0x000000EF; LBU 0x23 -> 0x000000DE.
- Faults (DEPTH=1024): SH 0x11 -> resp_misaligned=1 at T+1, mem_we never asserted; LW 0x3FE -> misaligned; LW 0x400 -> resp_access_fault=1; req_size=3 -> misaligned.
- SB 0x11 with rst pulsed during RMW_READ -> mem_we stays 0, no resp_valid, req_ready=1 after release, memory unchanged.
- req_valid held high with two queued requests -> the second is accepted only in the IDLE cycle after the first RESP, and req_ready=0 in all busy cycles.
